// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit (master) and imem (slave).
interface fetch_unit_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC, issues one imem request at a time, holds the word until exec_ack.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned next-PC redirects to TRAP_VEC and sets misalign_err.
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  fetch_unit_if.master    imem,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            exec_ack,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic [31:0]     fetch_count,
  output logic            misalign_err
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]      state;
  logic            vld_q;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] pc_next;

  assign pc_plus4       = pc + XLEN'(4);
  assign npc            = PCSrc ? PCTarget : pc_plus4;
  assign imem.imem_req  = (state == ST_REQ);
  assign imem.imem_addr = pc;
  // Valid is masked by reset so the core never sees a stale word during the reset cycle.
  assign instr_valid    = vld_q & ~reset;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis;
  logic err_q;

  assign mis          = |npc[1:0];
  assign pc_next      = mis ? TRAP_VEC : npc;
  assign misalign_err = err_q;

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (state == ST_HOLD && exec_ack && mis)
      err_q <= 1'b1;
  end
`else
  assign pc_next      = npc & ~XLEN'(3);
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      vld_q       <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        ST_REQ: begin
          // rvalid is deliberately not looked at here, even alongside ready.
          if (imem.imem_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem.imem_rvalid) begin
            instr <= imem.imem_rdata;
            vld_q <= 1'b1;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (exec_ack) begin
            pc          <= pc_next;
            instr       <= NOP_INSTR;
            vld_q       <= 1'b0;
            fetch_count <= fetch_count + 32'd1;
            state       <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transaction-level model updated by the driver tasks, checked every cycle.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, pc, pc_plus4, fetch_count, PCTarget;
  logic        instr_valid, exec_ack, PCSrc, misalign_err;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem(bus),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .exec_ack(exec_ack), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .fetch_count(fetch_count), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // Model of what the outputs must be after the most recent edge.
  logic [31:0] m_pc, m_instr, m_count;
  logic        m_valid, m_req, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && !reset) begin
      chk("imem_req",     {31'd0, bus.imem_req}, {31'd0, m_req});
      chk("imem_addr",    bus.imem_addr, m_pc);
      chk("pc",           pc, m_pc);
      chk("pc_plus4",     pc_plus4, m_pc + 32'd4);
      chk("instr",        instr, m_instr);
      chk("instr_valid",  {31'd0, instr_valid}, {31'd0, m_valid});
      chk("fetch_count",  fetch_count, m_count);
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_count = 0; m_valid = 0; m_req = 1; m_err = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    model_reset();
    reset = 1'b0;
    chk_on = 1'b1;
  endtask

  // From REQ: ready held low ready_wait cycles (junk rvalid present), then WAIT for rvalid_wait cycles.
  task automatic do_fetch(input logic [31:0] word, input int ready_wait, input int rvalid_wait);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_BAD0;
    repeat (ready_wait) tick();
    bus.imem_ready = 1'b1;
    tick();
    m_req = 1'b0;
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    exec_ack = 1'b1; PCSrc = 1'b1; PCTarget = 32'h0000_0800;
    repeat (rvalid_wait) tick();
    exec_ack = 1'b0; PCSrc = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = word;
    tick();
    m_instr = word; m_valid = 1'b1;
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic do_ack(input logic src, input logic [31:0] tgt, input int hold_wait);
    logic [31:0] npc;
    PCSrc = 1'b1; PCTarget = 32'h0000_0444;
    repeat (hold_wait) tick();
    exec_ack = 1'b1; PCSrc = src; PCTarget = tgt;
    tick();
    npc = src ? tgt : m_pc + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (npc[1:0] != 2'b00) begin
      m_pc = 32'h0000_0100; m_err = 1'b1;
    end else m_pc = npc;
`else
    m_pc = npc & ~32'd3;
`endif
    m_count = m_count + 1; m_valid = 0; m_instr = NOP; m_req = 1;
    exec_ack = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
  endtask

  logic [31:0] words [3] = '{32'h0050_0093, 32'h0010_8113, 32'hFE20_8EE3};

  initial begin
    reset = 1'b1; exec_ack = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    model_reset();

    // 1: reset state
    do_reset(2);
    @(negedge clk);
    chk("t1_pc", pc, 32'h0);
    chk("t1_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t1_addr", bus.imem_addr, 32'h0);
    chk("t1_instr", instr, 32'h0000_0013);
    chk("t1_valid", {31'd0, instr_valid}, 32'd0);
    chk("t1_count", fetch_count, 32'd0);

    // 2: three sequential fetches at minimum latency
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_addr", bus.imem_addr, 32'(i * 4));
      do_fetch(words[i], 0, 0);
      @(negedge clk);
      chk("t2_instr", instr, words[i]);
      do_ack(1'b0, 32'h0, 0);
    end
    @(negedge clk);
    chk("t2_count", fetch_count, 32'd3);

    // 3: taken branch to 0x100
    do_fetch(32'h1000_006F, 0, 1);
    do_ack(1'b1, 32'h0000_0100, 2);
    @(negedge clk);
    chk("t3_addr", bus.imem_addr, 32'h0000_0100);
    chk("t3_pc", pc, 32'h0000_0100);

    // 4: ready stalled 3 cycles
    do_fetch(32'h0000_0033, 3, 0);
    @(negedge clk);
    chk("t4_req", {31'd0, bus.imem_req}, 32'd0);
    do_ack(1'b0, 32'h0, 1);
    @(negedge clk);
    chk("t4_pc", pc, 32'h0000_0104);

    // 5: reset while in WAIT with a late response
    bus.imem_ready = 1'b1;
    tick();
    m_req = 1'b0;
    bus.imem_ready = 1'b0;
    reset = 1'b1;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    model_reset();
    reset = 1'b0;
    tick();
    bus.imem_rvalid = 1'b0;
    @(negedge clk);
    chk("t5_pc", pc, 32'h0);
    chk("t5_instr", instr, 32'h0000_0013);
    chk("t5_valid", {31'd0, instr_valid}, 32'd0);
    chk("t5_req", {31'd0, bus.imem_req}, 32'd1);

    // 6: misaligned target, then PC wrap-around
    do_fetch(32'h0020_0067, 0, 0);
    do_ack(1'b1, 32'h0000_0102, 0);
    @(negedge clk);
    chk("t6_pc", pc, 32'h0000_0100);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6_err", {31'd0, misalign_err}, 32'd1);
`else
    chk("t6_err", {31'd0, misalign_err}, 32'd0);
`endif
    do_fetch(32'h0000_0013, 0, 0);
    do_ack(1'b1, 32'hFFFF_FFFC, 0);
    @(negedge clk);
    chk("t6_pc_hi", pc, 32'hFFFF_FFFC);
    chk("t6_plus4", pc_plus4, 32'h0);
    do_fetch(32'h0000_0013, 1, 1);
    do_ack(1'b0, 32'h0, 0);
    @(negedge clk);
    chk("t6_wrap", pc, 32'h0);
    chk("t6_count", fetch_count, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
